// File: rtl/sample_buffer_responder_pkg.sv
// Shared types and defaults for the capture-buffer responder.
// Write-response codes and the default geometry of the sample store.
package sample_buffer_responder_pkg;

  typedef enum logic {
    BRESP_OKAY   = 1'b0,
    BRESP_SLVERR = 1'b1
  } bresp_e;

  localparam int DEF_I_BITS        = 12;
  localparam int DEF_Q_BITS        = 12;
  localparam int DEF_BUFFER_LENGTH = 1024;
  localparam int DEF_INDEX_BITS    = 10;

endpackage

// File: rtl/sample_buffer_responder_skid.sv
// Two-entry valid/ready skid with bypass: an empty skid forwards its input combinationally,
// so a registered RAM read reaches the port one cycle after the address was accepted.
module sample_buffer_skid #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] entry [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // NOTE: every signal gets a value before any branch in always_comb, so no latch is inferred.
  always_comb begin
    pop       = (count != 2'd0) && out_ready;
    push      = in_valid && !((count == 2'd0) && out_ready);
    out_valid = (count != 2'd0) || in_valid;
    out_data  = (count != 2'd0) ? entry[rd_ptr] : in_data;
  end

  // The caller only presents data when a slot is reserved, so push never hits a full skid.
  // NOTE: these two entries are reset because they drive i/q directly; the big RAM is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int e = 0; e < 2; e++) entry[e] <= '0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= in_data;
        wr_ptr        <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign level = count;

endmodule

// File: rtl/sample_buffer_responder.sv
// Responder for the caf capture buffer: addressed sample writes with a B channel, and
// addressed reads returning split I/Q through a skid at one sample per cycle.
module sample_buffer_responder
  import sample_buffer_responder_pkg::*;
#(
  parameter int I_BITS        = DEF_I_BITS,
  parameter int Q_BITS        = DEF_Q_BITS,
  parameter int BUFFER_LENGTH = DEF_BUFFER_LENGTH,
  parameter int INDEX_BITS    = DEF_INDEX_BITS,
  parameter bit BRESP_EN      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [INDEX_BITS-1:0]    m_axi_waddr,
  input  logic [I_BITS+Q_BITS-1:0] m_axi_wdata,
  input  logic                     m_axi_wvalid,
  output logic                     s_axi_wready,
  output logic                     s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     m_axi_bready,
  input  logic [INDEX_BITS-1:0]    m_axi_raddr,
  input  logic                     m_axi_rvalid,
  output logic                     s_axi_rready,
  output logic [I_BITS-1:0]        i,
  output logic [Q_BITS-1:0]        q,
  output logic                     s_axi_rvalid,
  output logic                     s_axi_rerr,
  input  logic                     m_axi_rready
);

  localparam int DW = I_BITS + Q_BITS;
  localparam int AW = (BUFFER_LENGTH > 1) ? $clog2(BUFFER_LENGTH) : 1;
  localparam logic [INDEX_BITS:0] LEN = (INDEX_BITS + 1)'(BUFFER_LENGTH);

  logic [DW-1:0] mem [BUFFER_LENGTH];
  logic [DW-1:0] ram_q;
  logic          alive;
  logic          w_in_range;
  logic          r_in_range;
  logic          w_fire;
  logic          r_fire;
  logic          pend;
  logic          pend_oor;
  logic [DW:0]   skid_in;
  logic [DW:0]   skid_out;
  logic [1:0]    skid_level;

  assign w_in_range = {1'b0, m_axi_waddr} < LEN;
  assign r_in_range = {1'b0, m_axi_raddr} < LEN;

  // Ready outputs stay low through reset and rise on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // A read is accepted only if the skid can still hold it together with the read in flight.
  always_comb begin
    s_axi_wready = alive && (!BRESP_EN || !s_axi_bvalid || m_axi_bready);
    s_axi_rready = alive && !((skid_level == 2'd2) || ((skid_level == 2'd1) && pend));
    w_fire       = m_axi_wvalid && s_axi_wready;
    r_fire       = m_axi_rvalid && s_axi_rready;
  end

  // NOTE: the RAM has no reset so it maps onto block RAM; both ports use <= so a
  // same-edge read of the written address returns the old word.
  always_ff @(posedge clk) begin
    if (w_fire && w_in_range) mem[m_axi_waddr[AW-1:0]] <= m_axi_wdata;
    if (r_fire && r_in_range) ram_q <= mem[m_axi_raddr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_oor <= 1'b0;
    end else begin
      pend     <= r_fire;
      pend_oor <= r_fire && !r_in_range;
    end
  end

  // Out-of-range reads carry zero data and the error flag through the same ordered path.
  always_comb begin
    skid_in = '0;
    if (pend && pend_oor) skid_in = {1'b1, {DW{1'b0}}};
    else if (pend)        skid_in = {1'b0, ram_q};
  end

  sample_buffer_skid #(
    .WIDTH (DW + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pend),
    .in_data   (skid_in),
    .out_ready (m_axi_rready),
    .out_valid (s_axi_rvalid),
    .out_data  (skid_out),
    .level     (skid_level)
  );

  assign s_axi_rerr = skid_out[DW];
  assign i          = skid_out[DW-1:Q_BITS];
  assign q          = skid_out[Q_BITS-1:0];

  // With BRESP_EN=0 the response is a one-cycle pulse per accepted write and bready is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= BRESP_OKAY;
    end else if (w_fire) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= w_in_range ? BRESP_OKAY : BRESP_SLVERR;
    end else if (!BRESP_EN || m_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_buffer_responder.sv
// Directed bench for sample_buffer_responder: a scoreboard queue of expected read responses
// plus a small write/response model, checked every cycle on the falling edge.
module tb_sample_buffer_responder;

  localparam int IB  = 12;
  localparam int QB  = 12;
  localparam int LEN = 1024;
  localparam int AB  = 11;

  typedef struct packed {
    logic          rerr;
    logic [IB-1:0] i;
    logic [QB-1:0] q;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AB-1:0]    waddr = '0;
  logic [IB+QB-1:0] wdata = '0;
  logic             wvalid = 1'b0;
  logic             bready = 1'b1;
  logic [AB-1:0]    raddr = '0;
  logic             rvalid = 1'b0;
  logic             rready_m = 1'b1;

  logic wready, bresp, bvalid, rready, rvalid_s, rerr;
  logic [IB-1:0] i;
  logic [QB-1:0] q;

  logic bready_x = 1'bx;
  logic rvalid0 = 1'b0;
  logic rready0_m = 1'b1;
  logic wready0, bresp0, bvalid0, rready0, rvalid0_s, rerr0;
  logic [IB-1:0] i0;
  logic [QB-1:0] q0;

  sample_buffer_responder #(
    .I_BITS(IB), .Q_BITS(QB), .BUFFER_LENGTH(LEN), .INDEX_BITS(AB), .BRESP_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axi_waddr(waddr), .m_axi_wdata(wdata), .m_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_raddr(raddr), .m_axi_rvalid(rvalid), .s_axi_rready(rready),
    .i(i), .q(q), .s_axi_rvalid(rvalid_s), .s_axi_rerr(rerr), .m_axi_rready(rready_m)
  );

  sample_buffer_responder #(
    .I_BITS(IB), .Q_BITS(QB), .BUFFER_LENGTH(LEN), .INDEX_BITS(AB), .BRESP_EN(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .m_axi_waddr(waddr), .m_axi_wdata(wdata), .m_axi_wvalid(wvalid),
    .s_axi_wready(wready0), .s_axi_bresp(bresp0), .s_axi_bvalid(bvalid0), .m_axi_bready(bready_x),
    .m_axi_raddr(raddr), .m_axi_rvalid(rvalid0), .s_axi_rready(rready0),
    .i(i0), .q(q0), .s_axi_rvalid(rvalid0_s), .s_axi_rerr(rerr0), .m_axi_rready(rready0_m)
  );

  logic [IB+QB-1:0] ref_mem [LEN];
  rsp_t sb [$];
  bit   exp_alive = 1'b0;
  bit   exp_bv = 1'b0;
  bit   exp_br = 1'b0;
  bit   exp_bv0 = 1'b0;
  bit   last_r_acc = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wready"}, 32'(wready), 32'(0));
    check({tag, "_rready"}, 32'(rready), 32'(0));
    check({tag, "_bvalid"}, 32'(bvalid), 32'(0));
    check({tag, "_bresp"},  32'(bresp), 32'(0));
    check({tag, "_rvalid"}, 32'(rvalid_s), 32'(0));
    check({tag, "_rdata"},  32'({rerr, i, q}), 32'(0));
    check({tag, "_wready0"}, 32'(wready0), 32'(0));
    check({tag, "_rready0"}, 32'(rready0), 32'(0));
    check({tag, "_bvalid0"}, 32'({bvalid0, bresp0}), 32'(0));
    check({tag, "_rdata0"},  32'({rvalid0_s, rerr0, i0, q0}), 32'(0));
  endtask

  // One clock: compare outputs mid-cycle against the model, then advance the model across the edge.
  task automatic step();
    bit   exp_wr, exp_rr, w_acc;
    rsp_t head, nxt;
    @(negedge clk);
    exp_wr = exp_alive && (!exp_bv || bready);
    exp_rr = exp_alive && (sb.size() < 2);
    check("wready", 32'(wready), 32'(exp_wr));
    check("bvalid", 32'(bvalid), 32'(exp_bv));
    if (exp_bv) check("bresp", 32'(bresp), 32'(exp_br));
    check("rready", 32'(rready), 32'(exp_rr));
    check("rvalid", 32'(rvalid_s), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      head = sb[0];
      check("rdata", 32'({rerr, i, q}), 32'(head));
    end
    check("wready0", 32'(wready0), 32'(exp_alive));
    check("bvalid0", 32'(bvalid0), 32'(exp_bv0));
    check("rvalid0", 32'(rvalid0_s), 32'(0));
    last_r_acc = rvalid && exp_rr;
    if (sb.size() != 0 && rready_m) void'(sb.pop_front());
    if (last_r_acc) begin
      if (raddr < AB'(LEN)) nxt = '{rerr: 1'b0, i: ref_mem[raddr[9:0]][IB+QB-1:QB], q: ref_mem[raddr[9:0]][QB-1:0]};
      else                  nxt = '0;
      if (raddr >= AB'(LEN)) nxt.rerr = 1'b1;
      sb.push_back(nxt);
    end
    w_acc = wvalid && exp_wr;
    if (w_acc && waddr < AB'(LEN)) ref_mem[waddr[9:0]] = wdata;
    if (w_acc) begin
      exp_bv = 1'b1;
      exp_br = (waddr >= AB'(LEN));
    end else if (bready) begin
      exp_bv = 1'b0;
    end
    exp_bv0 = wvalid && exp_alive;
    @(posedge clk);
    exp_alive = rst_n;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rpat [4];
    int next, cyc;
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1};

    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Writes 0..7 with {i=k, q=-k}, responses accepted immediately.
    for (int k = 0; k < 8; k++) begin
      wvalid = 1'b1; waddr = AB'(k); wdata = {IB'(k), QB'(-k)};
      step();
    end
    wvalid = 1'b0;
    step();

    // Back-to-back reads 0..7 with the initiator always ready.
    for (int k = 0; k < 8; k++) begin
      rvalid = 1'b1; raddr = AB'(k);
      step();
    end
    rvalid = 1'b0;
    repeat (2) step();

    // Read stream under initiator backpressure, starting with the 1,0,0,1 pattern.
    next = 0;
    cyc = 0;
    while ((next < 8 || sb.size() != 0) && cyc < 200) begin
      rvalid   = (next < 8);
      raddr    = AB'(next);
      rready_m = (cyc < 4) ? rpat[cyc] : 1'($urandom_range(0, 1));
      step();
      if (last_r_acc) next++;
      cyc++;
    end
    check("stream_complete", 32'(cyc < 200), 32'(1));
    rvalid = 1'b0;
    rready_m = 1'b1;
    step();

    // Out-of-range write is dropped with SLVERR; the aliasing word 0 must survive.
    wvalid = 1'b1; waddr = AB'(LEN); wdata = 24'h123456;
    step();
    wvalid = 1'b0;
    step();
    rvalid = 1'b1; raddr = AB'(LEN);
    step();
    raddr = AB'(0);
    step();
    rvalid = 1'b0;
    repeat (2) step();

    // Same-edge write and read of address 5, then a read of the new value.
    wvalid = 1'b1; waddr = AB'(5); wdata = 24'hAAA555;
    rvalid = 1'b1; raddr = AB'(5);
    step();
    wvalid = 1'b0;
    step();
    rvalid = 1'b0;
    repeat (2) step();

    // Held write response blocks the next write until bready returns.
    bready = 1'b0;
    wvalid = 1'b1; waddr = AB'(10); wdata = 24'h0A0F0A;
    step();
    waddr = AB'(11); wdata = 24'h0B0E0B;
    repeat (3) step();
    bready = 1'b1;
    step();
    wvalid = 1'b0;
    step();
    rvalid = 1'b1; raddr = AB'(10);
    step();
    raddr = AB'(11);
    step();
    rvalid = 1'b0;
    repeat (2) step();

    // Reset in the middle of a stalled read burst.
    rready_m = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; raddr = AB'(k);
      step();
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    sb.delete();
    exp_bv = 1'b0; exp_bv0 = 1'b0; exp_alive = 1'b0;
    rvalid = 1'b0; wvalid = 1'b0; rready_m = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();
    rvalid = 1'b1; raddr = AB'(3);
    step();
    raddr = AB'(5);
    step();
    rvalid = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
